// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed little-endian firmware image over a
// UART byte stream, writes it into the firmware RAM, then hands the RAM port to the CPU
// and releases CPU reset. With boot_en low at reset release the CPU is passed straight through.
module uart_boot_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        boot_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    output logic        ram_mem_valid,
    output logic        ram_mem_instr,
    output logic [31:0] ram_mem_addr,
    output logic [31:0] ram_mem_wdata,
    output logic [3:0]  ram_mem_wstrb,
    input  logic        ram_mem_ready,
    input  logic [31:0] ram_mem_rdata,
    output logic        cpu_resetn,
    output logic        boot_done,
    output logic        boot_error
);

    typedef enum logic [2:0] {
        StSample,
        StHdr,
        StData,
        StWrite,
        StRun,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] word_count_q, word_count_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic        skid_valid_q, skid_valid_d;
    logic [7:0]  skid_data_q, skid_data_d;
    logic [31:0] timer_q, timer_d;
    logic        hdr_started_q, hdr_started_d;
    logic        ram_valid_q, ram_valid_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        cpu_resetn_q, boot_done_q, boot_error_q;

    logic        byte_take;  // a byte enters the assembler this cycle
    logic [7:0]  byte_val;
    logic [31:0] asm_word;   // assembly buffer with byte_val merged in
    logic        timer_run;
    logic        last_word;

    assign last_word = (word_idx_q + 32'd1 == word_count_q);

    // Next-state logic: byte sourcing, word assembly, RAM write handshake and timeout
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        asm_d         = asm_q;
        word_count_d  = word_count_q;
        word_idx_d    = word_idx_q;
        skid_valid_d  = skid_valid_q;
        skid_data_d   = skid_data_q;
        timer_d       = timer_q;
        hdr_started_d = hdr_started_q;
        ram_valid_d   = ram_valid_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        byte_take     = 1'b0;
        byte_val      = rx_data;
        timer_run     = 1'b0;

        unique case (state_q)
            StSample: state_d = boot_en ? StHdr : StRun;
            StHdr: begin
                timer_run = hdr_started_q;
                byte_take = rx_valid;
            end
            StData: begin
                timer_run = 1'b1;
                if (skid_valid_q) begin
                    // Older skid byte goes first; a fresh byte refills the skid slot
                    byte_take    = 1'b1;
                    byte_val     = skid_data_q;
                    skid_valid_d = rx_valid;
                    skid_data_d  = rx_data;
                end else begin
                    byte_take = rx_valid;
                end
            end
            StWrite: begin
                timer_run = 1'b1;
                if (ram_mem_ready) begin
                    ram_valid_d = 1'b0;
                    word_idx_d  = word_idx_q + 32'd1;
                    state_d     = last_word ? StRun : StData;
                end
                if (rx_valid) begin
                    if (skid_valid_q) begin
                        state_d = StError;
                    end else if (ram_mem_ready) begin
                        byte_take = !last_word;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = rx_data;
                    end
                end
            end
            StRun, StError: ;
            default: state_d = StError;
        endcase

        asm_word = asm_q;
        asm_word[{byte_idx_q, 3'b000} +: 8] = byte_val;

        if (byte_take) begin
            asm_d      = asm_word;
            byte_idx_d = byte_idx_q + 2'd1;
            if (state_q == StHdr) begin
                hdr_started_d = 1'b1;
            end
            if (byte_idx_q == 2'd3) begin
                if (state_q == StHdr) begin
                    word_count_d = asm_word;
                    word_idx_d   = '0;
                    if (asm_word == 32'd0) begin
                        state_d = StRun;
                    end else if (asm_word > 32'(MAX_WORDS)) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end else begin
                    state_d     = StWrite;
                    ram_valid_d = 1'b1;
                    ram_addr_d  = BASE_ADDR + (word_idx_q << 2);
                    ram_wdata_d = asm_word;
                end
            end
        end

        // Inter-byte timeout; any received byte restarts the count
        if (rx_valid || !timer_run) begin
            timer_d = '0;
        end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d = StError;
        end else begin
            timer_d = timer_q + 32'd1;
        end

        if (state_d == StError) begin
            ram_valid_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StSample;
            byte_idx_q    <= '0;
            asm_q         <= '0;
            word_count_q  <= '0;
            word_idx_q    <= '0;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            timer_q       <= '0;
            hdr_started_q <= 1'b0;
            ram_valid_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            asm_q         <= asm_d;
            word_count_q  <= word_count_d;
            word_idx_q    <= word_idx_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            timer_q       <= timer_d;
            hdr_started_q <= hdr_started_d;
            ram_valid_q   <= ram_valid_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
        end
    end

    // Status outputs; CPU reset release lags RUN entry by one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_resetn_q <= 1'b0;
            boot_done_q  <= 1'b0;
            boot_error_q <= 1'b0;
        end else begin
            cpu_resetn_q <= (state_q == StRun);
            boot_done_q  <= (state_q == StRun);
            boot_error_q <= (state_d == StError);
        end
    end

    assign cpu_resetn = cpu_resetn_q;
    assign boot_done  = boot_done_q;
    assign boot_error = boot_error_q;

    // RAM port mux: CPU pass-through in RUN, loader-owned otherwise
    always_comb begin
        ram_mem_valid = ram_valid_q;
        ram_mem_instr = 1'b0;
        ram_mem_addr  = ram_addr_q;
        ram_mem_wdata = ram_wdata_q;
        ram_mem_wstrb = 4'hF;
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = '0;
        if (state_q == StRun) begin
            ram_mem_valid = cpu_mem_valid;
            ram_mem_instr = cpu_mem_instr;
            ram_mem_addr  = cpu_mem_addr;
            ram_mem_wdata = cpu_mem_wdata;
            ram_mem_wstrb = cpu_mem_wstrb;
            cpu_mem_ready = ram_mem_ready;
            cpu_mem_rdata = ram_mem_rdata;
        end
    end

endmodule
